// File: rtl/sdcard_cache.sv
// sdcard_cache: direct-mapped write-back byte cache in front of a 512-byte-line SD card glue.
// Defining SDCARD_CACHE_FLUSH_EN adds flush_req/flush_done and a whole-cache write-back scan.
module sdcard_cache #(
    parameter int ADDR  = 32,
    parameter int DATA  = 8,
    parameter int WIDTH = 4096,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cpu_valid,
    output logic             cpu_ready,
    input  logic             cpu_we,
    input  logic [ADDR-1:0]  cpu_addr,
    input  logic [DATA-1:0]  cpu_wdata,
    output logic             cpu_done,
    output logic [DATA-1:0]  cpu_rdata,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [ADDR-1:0]  mem_addr,
    output logic [WIDTH-1:0] mem_data,
    output logic             mem_cmd,
    input  logic             mem_rvalid,
    output logic             mem_rready,
    input  logic [WIDTH-1:0] mem_rdata
`ifdef SDCARD_CACHE_FLUSH_EN
    ,
    input  logic             flush_req,
    output logic             flush_done
`endif
);

    localparam int OFF_W = 9;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = ADDR - OFF_W - IDX_W;

    typedef enum logic [3:0] {
        IDLE, LOOKUP, WB_REQ, FILL_REQ, FILL_WAIT, RESP
`ifdef SDCARD_CACHE_FLUSH_EN
        , FLUSH_SCAN, FLUSH_WB, FLUSH_DONE
`endif
    } state_t;

    state_t state, state_next;

    logic [ADDR-1:0]  req_addr;
    logic             req_we;
    logic [DATA-1:0]  req_wdata;
    logic [DATA-1:0]  rdata_q;

    logic [DEPTH-1:0] line_valid;
    logic [DEPTH-1:0] line_dirty;
    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] way_idx;
    logic             hit;
    logic             victim_dirty;

    assign req_tag      = req_addr[ADDR-1 -: TAG_W];
    assign req_idx      = req_addr[OFF_W +: IDX_W];
    assign req_off      = req_addr[OFF_W-1:0];
    assign hit          = line_valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign victim_dirty = line_valid[req_idx] && line_dirty[req_idx];

`ifdef SDCARD_CACHE_FLUSH_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    logic [IDX_W-1:0] flush_idx;
    logic             flush_last;
    logic             flush_hit;

    assign flush_last = (flush_idx == LAST_IDX);
    assign flush_hit  = line_valid[flush_idx] && line_dirty[flush_idx];

    always_comb begin
        way_idx = req_idx;
        if (state == FLUSH_WB) way_idx = flush_idx;
    end
`else
    always_comb begin
        way_idx = req_idx;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
`ifdef SDCARD_CACHE_FLUSH_EN
                if (flush_req) state_next = FLUSH_SCAN;
                else
`endif
                if (cpu_valid) state_next = LOOKUP;
            end
            LOOKUP: begin
                if (hit)               state_next = RESP;
                else if (victim_dirty) state_next = WB_REQ;
                else                   state_next = FILL_REQ;
            end
            WB_REQ:    if (mem_ready)  state_next = FILL_REQ;
            FILL_REQ:  if (mem_ready)  state_next = FILL_WAIT;
            FILL_WAIT: if (mem_rvalid) state_next = LOOKUP;
            RESP:                      state_next = IDLE;
`ifdef SDCARD_CACHE_FLUSH_EN
            FLUSH_SCAN: begin
                if (flush_hit)       state_next = FLUSH_WB;
                else if (flush_last) state_next = FLUSH_DONE;
            end
            FLUSH_WB: begin
                if (mem_ready) state_next = flush_last ? FLUSH_DONE : FLUSH_SCAN;
            end
            FLUSH_DONE:                state_next = IDLE;
`endif
            default:                   state_next = IDLE;
        endcase
    end

    always_comb begin
        cpu_ready  = (state == IDLE);
        cpu_done   = (state == RESP);
        mem_valid  = (state == WB_REQ) || (state == FILL_REQ);
        mem_cmd    = (state == WB_REQ);
        mem_rready = (state == FILL_WAIT);
`ifdef SDCARD_CACHE_FLUSH_EN
        cpu_ready  = (state == IDLE) && !flush_req;
        mem_valid  = mem_valid || (state == FLUSH_WB);
        mem_cmd    = mem_cmd || (state == FLUSH_WB);
        flush_done = (state == FLUSH_DONE);
`endif
        // Write-backs address the victim (or flushed) line; fills address the request.
        mem_addr   = mem_cmd ? {tag_mem[way_idx], way_idx, 9'h000}
                             : {req_tag, req_idx, 9'h000};
        mem_data   = data_mem[way_idx];
        cpu_rdata  = rdata_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            line_valid <= '0;
            line_dirty <= '0;
            rdata_q    <= '0;
            req_addr   <= '0;
            req_we     <= 1'b0;
            req_wdata  <= '0;
`ifdef SDCARD_CACHE_FLUSH_EN
            flush_idx  <= '0;
`endif
        end else begin
            if (cpu_ready && cpu_valid) begin
                req_addr  <= cpu_addr;
                req_we    <= cpu_we;
                req_wdata <= cpu_wdata;
            end
            case (state)
                LOOKUP: begin
                    if (hit) begin
                        if (req_we) line_dirty[req_idx] <= 1'b1;
                        else        rdata_q <= data_mem[req_idx][{req_off, 3'b000} +: DATA];
                    end
                end
                WB_REQ: if (mem_ready) line_dirty[req_idx] <= 1'b0;
                FILL_WAIT: begin
                    if (mem_rvalid) begin
                        line_valid[req_idx] <= 1'b1;
                        line_dirty[req_idx] <= 1'b0;
                    end
                end
`ifdef SDCARD_CACHE_FLUSH_EN
                IDLE: if (flush_req) flush_idx <= '0;
                FLUSH_SCAN: begin
                    if (!flush_hit && !flush_last) flush_idx <= flush_idx + 1'b1;
                end
                FLUSH_WB: begin
                    if (mem_ready) begin
                        line_dirty[flush_idx] <= 1'b0;
                        if (!flush_last) flush_idx <= flush_idx + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Line storage has no reset; gating on reset keeps an abandoned fill from landing.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == LOOKUP && hit && req_we)
                data_mem[req_idx][{req_off, 3'b000} +: DATA] <= req_wdata;
            if (state == FILL_WAIT && mem_rvalid) begin
                data_mem[req_idx] <= mem_rdata;
                tag_mem[req_idx]  <= req_tag;
            end
        end
    end

endmodule

// File: tb/tb_sdcard_cache.sv
// Scoreboard bench for sdcard_cache: a tag/byte model predicts CPU results and SD line traffic,
// a responder models the SD glue backing store.
module tb_sdcard_cache;

    logic             clock;
    logic             reset;
    logic             cpu_valid;
    logic             cpu_ready;
    logic             cpu_we;
    logic [31:0]      cpu_addr;
    logic [7:0]       cpu_wdata;
    logic             cpu_done;
    logic [7:0]       cpu_rdata;
    logic             mem_valid;
    logic             mem_ready;
    logic [31:0]      mem_addr;
    logic [4095:0]    mem_data;
    logic             mem_cmd;
    logic             mem_rvalid;
    logic             mem_rready;
    logic [4095:0]    mem_rdata;

    sdcard_cache #(.ADDR(32), .DATA(8), .WIDTH(4096), .DEPTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_valid  (cpu_valid),
        .cpu_ready  (cpu_ready),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_done   (cpu_done),
        .cpu_rdata  (cpu_rdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_cmd    (mem_cmd),
        .mem_rvalid (mem_rvalid),
        .mem_rready (mem_rready),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic          cmd;
        logic [31:0]   addr;
        logic [4095:0] data;
    } mem_exp_t;

    typedef struct {
        logic       is_read;
        logic [7:0] rdata;
        logic       hit;
        int         acc;
    } done_exp_t;

    mem_exp_t   exp_mem_q[$];
    done_exp_t  exp_done_q[$];
    logic [7:0] cpu_model [logic [31:0]];
    logic [7:0] mem_model [logic [31:0]];
    logic       tb_valid [8];
    logic       tb_dirty [8];
    logic [19:0] tb_tag  [8];

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   mem_req_cnt = 0;
    logic mem_ready_en = 1'b1;
    logic hold_fill = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fill_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hB4;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return fill_byte(a);
    endfunction

    function automatic logic [7:0] exp_byte(input logic [31:0] a);
        if (cpu_model.exists(a)) return cpu_model[a];
        return mem_byte(a);
    endfunction

    task automatic predict(input logic we, input logic [31:0] a, input logic [7:0] wd,
                           output logic hit, output logic [7:0] rd, output int nreq);
        logic [2:0]  idx;
        logic [19:0] tag;
        mem_exp_t    e;
        idx  = a[11:9];
        tag  = a[31:12];
        hit  = tb_valid[idx] && (tb_tag[idx] == tag);
        nreq = 0;
        if (!hit) begin
            if (tb_valid[idx] && tb_dirty[idx]) begin
                e.cmd  = 1'b1;
                e.addr = {tb_tag[idx], idx, 9'h000};
                for (int b = 0; b < 512; b++) e.data[8*b +: 8] = exp_byte(e.addr + 32'(b));
                exp_mem_q.push_back(e);
                nreq++;
            end
            e.cmd  = 1'b0;
            e.addr = {tag, idx, 9'h000};
            e.data = '0;
            exp_mem_q.push_back(e);
            nreq++;
            tb_valid[idx] = 1'b1;
            tb_tag[idx]   = tag;
            tb_dirty[idx] = 1'b0;
        end
        rd = exp_byte(a);
        if (we) begin
            cpu_model[a]  = wd;
            tb_dirty[idx] = 1'b1;
        end
    endtask

    task automatic cpu_op(input logic we, input logic [31:0] a, input logic [7:0] wd);
        logic      hit;
        logic [7:0] rd;
        int        nreq, cnt0, d0, t;
        done_exp_t d;
        predict(we, a, wd, hit, rd, nreq);
        t = 0;
        @(negedge clock);
        while (!cpu_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (!cpu_ready) begin
            check("cpu_ready_timeout", 0, 1);
            return;
        end
        d.is_read = !we;
        d.rdata   = rd;
        d.hit     = hit;
        d.acc     = cyc;
        exp_done_q.push_back(d);
        cnt0 = mem_req_cnt;
        d0   = done_cnt;
        cpu_valid = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        @(posedge clock);
        #1 cpu_valid = 1'b0;
        t = 0;
        while (done_cnt == d0 && t < 1000) begin
            @(negedge clock);
            t++;
        end
        if (done_cnt == d0) begin
            check("cpu_done_timeout", 0, 1);
            return;
        end
        if (hit) check("hit_mem_reqs", 64'(mem_req_cnt - cnt0), 64'(nreq));
        else     check("miss_mem_reqs", 64'(mem_req_cnt - cnt0), 64'(nreq));
    endtask

    task automatic check_reset_outputs();
        check("rst_cpu_ready", cpu_ready, 1);
        check("rst_cpu_done", cpu_done, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_rready", mem_rready, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            tb_valid[i] = 1'b0;
            tb_dirty[i] = 1'b0;
            tb_tag[i]   = '0;
        end
        cpu_model.delete();
    endtask

    // Completion monitor: every cpu_done pops one expected response.
    always @(negedge clock) begin
        done_exp_t d;
        if (!reset && cpu_done) begin
            if (exp_done_q.size() == 0) begin
                check("cpu_done_unexpected", 1, 0);
            end else begin
                d = exp_done_q.pop_front();
                if (d.is_read) check("cpu_rdata", cpu_rdata, d.rdata);
                if (d.hit)     check("hit_latency", 64'(cyc - d.acc), 2);
            end
            done_cnt++;
        end
    end

    // SD glue model: accepts line requests, checks them, returns fills from its backing store.
    initial begin
        logic          pending;
        int            fill_delay;
        logic [4095:0] fill_line;
        mem_exp_t      e;
        int            diffs;
        pending    = 1'b0;
        fill_delay = 0;
        fill_line  = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clock);
            mem_ready = mem_ready_en;
            if (reset) begin
                pending    = 1'b0;
                mem_rvalid = 1'b0;
            end else begin
                mem_rvalid = 1'b0;
                if (pending && !hold_fill) begin
                    if (fill_delay > 0) fill_delay--;
                    else if (mem_rready) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = fill_line;
                        pending    = 1'b0;
                    end
                end
                if (mem_valid && mem_ready) begin
                    mem_req_cnt++;
                    if (exp_mem_q.size() == 0) begin
                        check("mem_req_unexpected", 1, 0);
                    end else begin
                        e = exp_mem_q.pop_front();
                        check("mem_cmd", mem_cmd, e.cmd);
                        check("mem_addr", mem_addr, e.addr);
                        if (e.cmd) begin
                            diffs = 0;
                            for (int b = 0; b < 512; b++) begin
                                if (mem_data[8*b +: 8] !== e.data[8*b +: 8]) diffs++;
                                mem_model[e.addr + 32'(b)] = mem_data[8*b +: 8];
                            end
                            check("wb_data_bytes_wrong", 64'(diffs), 0);
                        end else begin
                            for (int b = 0; b < 512; b++)
                                fill_line[8*b +: 8] = mem_byte(e.addr + 32'(b));
                            pending    = 1'b1;
                            fill_delay = 2;
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic        hit;
        logic [7:0]  rd;
        int          nreq, t;
        logic [31:0] a;
        logic [31:0] stall_addr;
        reset     = 1'b1;
        cpu_valid = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        clear_model();
        repeat (3) @(negedge clock);
        check_reset_outputs();
        reset = 1'b0;

        cpu_op(1'b0, 32'h0000_1203, 8'h00);
        cpu_op(1'b1, 32'h0000_1204, 8'h5A);
        cpu_op(1'b0, 32'h0000_1204, 8'h00);
        cpu_op(1'b0, 32'h0000_3204, 8'h00);
        cpu_op(1'b0, 32'h0000_1204, 8'h00);
        cpu_op(1'b0, 32'h0000_1205, 8'h00);

        for (int i = 0; i < 40; i++) begin
            a = {17'h0, 3'($urandom_range(0, 2) * 2 + 1), 3'($urandom_range(0, 7)),
                 9'($urandom_range(0, 511))};
            cpu_op(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)));
        end

        // Stalled fill request: fields must hold and the CPU side must stay closed.
        mem_ready_en = 1'b0;
        stall_addr = 32'h0000_7400;
        fork
            cpu_op(1'b0, stall_addr, 8'h00);
            begin
                logic [31:0] ea;
                t = 0;
                @(negedge clock);
                while (!mem_valid && t < 20) begin
                    @(negedge clock);
                    t++;
                end
                check("stall_mem_valid_seen", mem_valid, 1);
                ea = (exp_mem_q.size() > 0) ? exp_mem_q[0].addr : 32'hFFFF_FFFF;
                for (int k = 0; k < 20; k++) begin
                    check("stall_mem_valid", mem_valid, 1);
                    check("stall_mem_addr", mem_addr, ea);
                    check("stall_cpu_ready", cpu_ready, 0);
                    @(negedge clock);
                end
                mem_ready_en = 1'b1;
            end
        join

        // Reset while waiting for a fill: transfer is abandoned, the next access misses again.
        a = 32'h0000_9600;
        hold_fill = 1'b1;
        predict(1'b0, a, 8'h00, hit, rd, nreq);
        t = 0;
        @(negedge clock);
        while (!cpu_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        cpu_valid = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = a;
        @(posedge clock);
        #1 cpu_valid = 1'b0;
        t = 0;
        @(negedge clock);
        while (!mem_rready && t < 100) begin
            @(negedge clock);
            t++;
        end
        check("rst_reached_fill_wait", mem_rready, 1);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_reset_outputs();
        check("rst_mem_reqs_left", 64'(exp_mem_q.size()), 0);
        reset = 1'b0;
        clear_model();
        exp_mem_q.delete();
        hold_fill = 1'b0;
        cpu_op(1'b0, a, 8'h00);
        cpu_op(1'b0, a + 32'd1, 8'h00);

        repeat (4) @(negedge clock);
        check("done_queue_empty", 64'(exp_done_q.size()), 0);
        check("mem_queue_empty", 64'(exp_mem_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
